// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider, ratio N or N+0.5.
// Ratio updates are handshaked in and only take effect at a sequence
// boundary, so clk_out never shows runt pulses.
// Optional feature macro: CLK_DIV_CTRL_HALF_EN enables the half-integer
// ratios (period-B negedge flops). Without it, half requests are rejected.

module clk_div_ctrl #(
   parameter int CNT_W    = 5,
   parameter int DEF_N    = 4,
   parameter int DEF_HALF = 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_n,
   input  logic             cfg_half,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             ratio_upd,
   output logic             busy,
   output logic             clk_out
);

   // Sequence counter must hold up to 2N for half mode.
   localparam int CW = CNT_W + 1;

`ifdef CLK_DIV_CTRL_HALF_EN
   localparam logic HALF_EN = 1'b1;
`else
   localparam logic HALF_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] RST_N    = CNT_W'(DEF_N);
   localparam logic             RST_HALF = HALF_EN && (DEF_HALF != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] act_n_q, act_n_d;
   logic             act_half_q, act_half_d;
   logic [CNT_W-1:0] shd_n_q, shd_n_d;
   logic             shd_half_q, shd_half_d;
   logic             shd_vld_q, shd_vld_d;
   logic             pos_q, pos_d;
   logic             ext_q, ext_d;
   logic             cfg_err_q, cfg_err_d;
   logic             ratio_upd_q, ratio_upd_d;

   logic accept;
   logic legal;
   logic take;
   logic boundary;

   // Last count value of a sequence: N-1 for integer ratios, 2N for half.
   function automatic logic [CW-1:0] seq_last(input logic [CNT_W-1:0] n,
                                               input logic half);
      logic [CW-1:0] n_ext;
      n_ext = {1'b0, n};
      if (half) seq_last = {n, 1'b0};
      else      seq_last = n_ext - CW'(1);
   endfunction

   // Posedge-domain high length: floor(N/2), or floor((N+1)/2) per half period.
   function automatic logic [CW-1:0] high_len(input logic [CNT_W-1:0] n,
                                               input logic half);
      logic [CW-1:0] n_ext;
      n_ext = {1'b0, n};
      if (half) high_len = (n_ext + CW'(1)) >> 1;
      else      high_len = n_ext >> 1;
   endfunction

   assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign cfg_err   = cfg_err_q;
   assign ratio_upd = ratio_upd_q;

   assign accept   = cfg_valid && cfg_ready;
   assign legal    = (cfg_n >= CNT_W'(2)) && (HALF_EN || !cfg_half);
   assign take     = accept && legal;
   assign boundary = (cnt_q == seq_last(act_n_q, act_half_q));

   // Next-state logic: FSM transitions, ratio/shadow bookkeeping, counter
   // and the posedge half of the output waveform (period A / integer high).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      act_n_d     = act_n_q;
      act_half_d  = act_half_q;
      shd_n_d     = shd_n_q;
      shd_half_d  = shd_half_q;
      shd_vld_d   = shd_vld_q;
      cfg_err_d   = accept && !legal;
      ratio_upd_d = 1'b0;
      pos_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (take) begin
               act_n_d     = cfg_n;
               act_half_d  = cfg_half;
               ratio_upd_d = 1'b1;
            end
            if (en) begin
               // Park on the boundary so the next posedge wraps to cnt=0.
               state_d = RUN;
               cnt_d   = seq_last(act_n_d, act_half_d);
            end else begin
               cnt_d = '0;
            end
         end
         RUN: begin
            if (!en) begin
               if (boundary) begin
                  state_d = IDLE;
                  if (take) begin
                     act_n_d     = cfg_n;
                     act_half_d  = cfg_half;
                     ratio_upd_d = 1'b1;
                  end
               end else begin
                  state_d = STOP;
                  if (take) begin
                     shd_n_d    = cfg_n;
                     shd_half_d = cfg_half;
                     shd_vld_d  = 1'b1;
                  end
               end
            end else if (take) begin
               state_d    = PEND;
               shd_n_d    = cfg_n;
               shd_half_d = cfg_half;
               shd_vld_d  = 1'b1;
            end
         end
         PEND, STOP: begin
            if (boundary) begin
               state_d = en ? RUN : IDLE;
               if (shd_vld_q) begin
                  act_n_d     = shd_n_q;
                  act_half_d  = shd_half_q;
                  shd_vld_d   = 1'b0;
                  ratio_upd_d = 1'b1;
               end
            end else if (en) begin
               state_d = shd_vld_q ? PEND : RUN;
            end else begin
               state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         if ((state_d == IDLE) || boundary) cnt_d = '0;
         else                              cnt_d = cnt_q + CW'(1);
      end

      pos_d = (state_d != IDLE) && (cnt_d < high_len(act_n_d, act_half_d));
   end

   // Posedge state register with asynchronous reset to the default ratio.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         act_n_q     <= RST_N;
         act_half_q  <= RST_HALF;
         shd_n_q     <= '0;
         shd_half_q  <= 1'b0;
         shd_vld_q   <= 1'b0;
         pos_q       <= 1'b0;
         cfg_err_q   <= 1'b0;
         ratio_upd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         act_n_q     <= act_n_d;
         act_half_q  <= act_half_d;
         shd_n_q     <= shd_n_d;
         shd_half_q  <= shd_half_d;
         shd_vld_q   <= shd_vld_d;
         pos_q       <= pos_d;
         cfg_err_q   <= cfg_err_d;
         ratio_upd_q <= ratio_upd_d;
      end
   end

   // Odd integer N: delay the posedge high by half a cycle for 50% duty.
   always_comb begin
      ext_d = pos_q && act_n_q[0] && !act_half_q;
   end

   // Negedge flop for the odd-N duty extension.
   always_ff @(negedge clk_in or posedge rst) begin
      if (rst) ext_q <= 1'b0;
      else     ext_q <= ext_d;
   end

`ifdef CLK_DIV_CTRL_HALF_EN
   logic perb_q, perb_d;

   // Period B of a half ratio: high on negedges inside cnt N .. N+H-1.
   always_comb begin
      perb_d = (state_q != IDLE) && act_half_q &&
               (cnt_q >= {1'b0, act_n_q}) &&
               (cnt_q < ({1'b0, act_n_q} + high_len(act_n_q, 1'b1)));
   end

   // Negedge flop realising period B, starting at time N+0.5.
   always_ff @(negedge clk_in or posedge rst) begin
      if (rst) perb_q <= 1'b0;
      else     perb_q <= perb_d;
   end

   assign clk_out = pos_q | ext_q | perb_q;
`else
   assign clk_out = pos_q | ext_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. Output periods and high times are
// measured on clk_out edges and compared against a queue of expectations.
`timescale 1ns/1ps

module tb_clk_div_ctrl;

   localparam int CNT_W = 5;

`ifdef CLK_DIV_CTRL_HALF_EN
   localparam int              DEF_PER = 45;
   localparam int              DEF_HI  = 20;
   localparam logic [CNT_W-1:0] T4_N   = 5'd7;
   localparam logic            T4_H    = 1'b1;
   localparam int              T4_PER  = 75;
   localparam int              T4_HI   = 40;
`else
   localparam int              DEF_PER = 40;
   localparam int              DEF_HI  = 20;
   localparam logic [CNT_W-1:0] T4_N   = 5'd5;
   localparam logic            T4_H    = 1'b0;
   localparam int              T4_PER  = 50;
   localparam int              T4_HI   = 25;
`endif

   logic             clk_in    = 1'b0;
   logic             rst       = 1'b1;
   logic             en        = 1'b0;
   logic [CNT_W-1:0] cfg_n     = '0;
   logic             cfg_half  = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic             cfg_err;
   logic             ratio_upd;
   logic             busy;
   logic             clk_out;

   typedef struct {
      int period;
      int high;
   } exp_t;

   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   lastRise    = 0;
   int   lastFall    = 0;
   bit   haveLast    = 1'b0;
   int   lastEpoch   = 0;
   int   monEpoch    = 0;
   bit   monOn       = 1'b0;

   bit   found;
   bit   fallSeen;
   bit   rdyB, errB, updB;
   int   tR, tF, tDrive;

   always #5 clk_in = ~clk_in;

   clk_div_ctrl #(.CNT_W(CNT_W), .DEF_N(4), .DEF_HALF(1)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .cfg_n    (cfg_n),
      .cfg_half (cfg_half),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_err  (cfg_err),
      .ratio_upd(ratio_upd),
      .busy     (busy),
      .clk_out  (clk_out)
   );

   task automatic checkOutput(input string tag, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Each clk_out rise closes one output period; compare it to the queue head.
   always @(posedge clk_out) begin
      exp_t e;
      if (monOn && haveLast && (lastEpoch == monEpoch) && (expQ.size() > 0)) begin
         e = expQ.pop_front();
         checkOutput("period", int'($time) - lastRise, e.period);
         checkOutput("high", lastFall - lastRise, e.high);
      end
      lastRise  = int'($time);
      lastFall  = lastRise;
      haveLast  = 1'b1;
      lastEpoch = monEpoch;
   end

   always @(negedge clk_out) lastFall = int'($time);

   // Config handshake driven for one cycle; flags sampled one cycle later.
   task automatic applyStimulus(input logic [CNT_W-1:0] n, input logic h,
                                output bit rdy, output bit err, output bit upd);
      @(negedge clk_in);
      rdy       = cfg_ready;
      cfg_n     = n;
      cfg_half  = h;
      cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_valid = 1'b0;
      err       = cfg_err;
      upd       = ratio_upd;
   endtask

   task automatic runScoreboard(input int per, input int hi, input int count, input string tag);
      for (int i = 0; i < count; i++) expQ.push_back('{per, hi});
      monEpoch++;
      monOn = 1'b1;
      for (int c = 0; c < 20 * (count + 2); c++) begin
         @(negedge clk_in);
         if (expQ.size() == 0) break;
      end
      checkOutput({tag, "_left"}, expQ.size(), 0);
      expQ.delete();
      monOn = 1'b0;
   endtask

   task automatic waitRise(input int maxEdges, output bit ok, output int t);
      bit prev;
      prev = clk_out;
      ok   = 1'b0;
      t    = 0;
      for (int i = 0; i < maxEdges; i++) begin
         @(clk_in);
         #1;
         if (!prev && (clk_out === 1'b1)) begin
            ok = 1'b1;
            t  = int'($time) - 1;
            break;
         end
         prev = clk_out;
      end
   endtask

   task automatic waitUpd(input int maxCycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk_in);
         if (ratio_upd === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk_in);
      checkOutput("rst_clk_out", clk_out, 0);
      checkOutput("rst_cfg_ready", cfg_ready, 1);
      checkOutput("rst_cfg_err", cfg_err, 0);
      checkOutput("rst_ratio_upd", ratio_upd, 0);
      checkOutput("rst_busy", busy, 0);
      rst = 1'b0;

      // Default ratio, start latency of one clk_in cycle
      @(negedge clk_in);
      en     = 1'b1;
      tDrive = int'($time);
      waitRise(10, found, tR);
      checkOutput("first_rise_found", found, 1);
      checkOutput("rise_latency", tR - (tDrive + 5), 10);
      checkOutput("run_busy", busy, 1);
      runScoreboard(DEF_PER, DEF_HI, 3, "def");

      // Reconfigure while running: ready drops until the boundary
      applyStimulus(T4_N, T4_H, rdyB, errB, updB);
      checkOutput("t4_ready_before", rdyB, 1);
      checkOutput("t4_err", errB, 0);
      checkOutput("t4_ready_pend", cfg_ready, 0);
      waitUpd(40, found);
      checkOutput("t4_upd_found", found, 1);
      checkOutput("t4_ready_after", cfg_ready, 1);
      runScoreboard(T4_PER, T4_HI, 3, "t4");

      // Illegal configs are dropped without disturbing the running ratio
`ifndef CLK_DIV_CTRL_HALF_EN
      applyStimulus(5'd3, 1'b1, rdyB, errB, updB);
      checkOutput("half_rej_err", errB, 1);
      checkOutput("half_rej_upd", updB, 0);
      checkOutput("half_rej_ready", cfg_ready, 1);
`endif
      applyStimulus(5'd1, 1'b0, rdyB, errB, updB);
      checkOutput("n1_err", errB, 1);
      checkOutput("n1_upd", updB, 0);
      checkOutput("n1_busy", busy, 1);
      checkOutput("n1_ready", cfg_ready, 1);
      @(negedge clk_in);
      checkOutput("err_one_cycle", cfg_err, 0);
      runScoreboard(T4_PER, T4_HI, 2, "keep");

      // Drop en mid-sequence: the current pulse completes, then IDLE
      waitRise(40, found, tR);
      checkOutput("stop_rise_found", found, 1);
      @(negedge clk_in);
      en       = 1'b0;
      fallSeen = 1'b0;
      tF       = 0;
      for (int i = 0; i < 80; i++) begin
         @(clk_in);
         #1;
         if (!fallSeen && (clk_out === 1'b0)) begin
            fallSeen = 1'b1;
            tF       = int'($time) - 1;
         end
         if (busy === 1'b0) break;
      end
      checkOutput("stop_busy", busy, 0);
      checkOutput("stop_tail_high", tF - tR, T4_HI);
      checkOutput("stop_clk_low", clk_out, 0);
      waitRise(20, found, tR);
      checkOutput("idle_no_rise", found, 0);

      // Config in IDLE goes straight to active with a ratio_upd pulse
      applyStimulus(5'd7, 1'b0, rdyB, errB, updB);
      checkOutput("idle_ready", rdyB, 1);
      checkOutput("idle_upd", updB, 1);
      checkOutput("idle_err", errB, 0);
      en = 1'b1;
      runScoreboard(70, 35, 3, "n7");

      // Config accepted in the same cycle en drops: applied at the boundary
      waitRise(40, found, tR);
      @(negedge clk_in);
      en        = 1'b0;
      cfg_n     = 5'd6;
      cfg_half  = 1'b0;
      cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_valid = 1'b0;
      checkOutput("drop_cfg_ready", cfg_ready, 0);
      checkOutput("drop_cfg_busy", busy, 1);
      waitUpd(40, found);
      checkOutput("drop_upd_found", found, 1);
      checkOutput("drop_upd_idle", busy, 0);
      checkOutput("drop_upd_clk", clk_out, 0);
      en = 1'b1;
      runScoreboard(60, 30, 3, "n6");

      // Asynchronous reset while clk_out is high, then default ratio again
      waitRise(40, found, tR);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_clk_out", clk_out, 0);
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_ready", cfg_ready, 1);
      en = 1'b0;
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      en     = 1'b1;
      tDrive = int'($time);
      waitRise(10, found, tR);
      checkOutput("arst_rise_latency", tR - (tDrive + 5), 10);
      runScoreboard(DEF_PER, DEF_HI, 2, "arst_def");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
